// File: rtl/eth_idma_reg_sequencer.sv
// eth_idma_reg_sequencer: register-bus master that programs and launches one
// eth_idma_wrap instance from a compact transfer command.
module eth_idma_reg_sequencer #(
  parameter int unsigned PollMax       = 16,
  parameter bit          RejectZeroLen = 1'b1,
  parameter logic [2:0]  ProtoAxi      = 3'd0,
  parameter logic [2:0]  ProtoAxis     = 3'd5
) (
  input  logic        s_clk,
  input  logic        s_rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_dir_i,
  input  logic [31:0] cmd_src_addr_i,
  input  logic [31:0] cmd_dst_addr_i,
  input  logic [31:0] cmd_len_i,
  input  logic        cmd_mac_upd_i,
  input  logic [47:0] mac_addr_i,
  input  logic [15:0] mac_cfg_i,
  output logic [31:0] reg_addr_o,
  output logic        reg_write_o,
  output logic [31:0] reg_wdata_o,
  output logic [3:0]  reg_wstrb_o,
  output logic        reg_valid_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_error_i,
  input  logic        reg_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int unsigned CntW = $clog2(PollMax + 1);

  typedef enum logic [3:0] {
    StIdle, StCheck, StMacLo, StMacHi, StSrc, StDst, StLen, StSprot,
    StDprot, StPoll, StLaunch, StLock, StRsp, StDone, StErr
  } state_e;

  state_e          state_q;
  logic            dir_q;
  logic [31:0]     src_q;
  logic [31:0]     dst_q;
  logic [31:0]     len_q;
  logic            mac_pending_q;
  logic [CntW-1:0] poll_cnt_q;

  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic            acc_write;
  state_e          acc_next;

  // Only the ready bit of the status register matters.
  logic unused_rdata;
  assign unused_rdata = ^reg_rdata_i[31:1];

  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);

  // Decode the register access owned by the current state and its successor.
  always_comb begin
    acc_addr  = 32'h0;
    acc_wdata = 32'h0;
    acc_write = 1'b1;
    acc_next  = StIdle;
    case (state_q)
      StMacLo: begin
        acc_addr  = 32'h00;
        acc_wdata = mac_addr_i[31:0];
        acc_next  = StMacHi;
      end
      StMacHi: begin
        acc_addr  = 32'h04;
        acc_wdata = {mac_cfg_i, mac_addr_i[47:32]};
        acc_next  = StSrc;
      end
      StSrc: begin
        acc_addr  = 32'h10;
        acc_wdata = src_q;
        acc_next  = StDst;
      end
      StDst: begin
        acc_addr  = 32'h14;
        acc_wdata = dst_q;
        acc_next  = StLen;
      end
      StLen: begin
        acc_addr  = 32'h18;
        acc_wdata = len_q;
        acc_next  = StSprot;
      end
      StSprot: begin
        acc_addr  = 32'h1C;
        acc_wdata = {29'h0, dir_q ? ProtoAxis : ProtoAxi};
        acc_next  = StDprot;
      end
      StDprot: begin
        acc_addr  = 32'h20;
        acc_wdata = {29'h0, dir_q ? ProtoAxi : ProtoAxis};
        acc_next  = StPoll;
      end
      StPoll: begin
        acc_addr  = 32'h3C;
        acc_write = 1'b0;
        acc_next  = StLaunch;
      end
      StLaunch: begin
        acc_addr  = 32'h38;
        acc_wdata = 32'h1;
        acc_next  = StLock;
      end
      StLock: begin
        acc_addr  = 32'h38;
        acc_wdata = 32'h0;
        acc_next  = StRsp;
      end
      StRsp: begin
        acc_addr  = 32'h40;
        acc_wdata = 32'h1;
        acc_next  = StDone;
      end
      default: begin
        acc_write = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered bus outputs and status pulses.
  always_ff @(posedge s_clk or posedge s_rst_n) begin
    if (s_rst_n) begin
      state_q       <= StIdle;
      dir_q         <= 1'b0;
      src_q         <= 32'h0;
      dst_q         <= 32'h0;
      len_q         <= 32'h0;
      mac_pending_q <= 1'b1;
      poll_cnt_q    <= '0;
      reg_addr_o    <= 32'h0;
      reg_write_o   <= 1'b0;
      reg_wdata_o   <= 32'h0;
      reg_wstrb_o   <= 4'h0;
      reg_valid_o   <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      err_code_o    <= 2'd0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            dir_q      <= cmd_dir_i;
            src_q      <= cmd_src_addr_i;
            dst_q      <= cmd_dst_addr_i;
            len_q      <= cmd_len_i;
            err_code_o <= 2'd0;
            if (cmd_mac_upd_i) mac_pending_q <= 1'b1;
            state_q    <= StCheck;
          end
        end
        StCheck: begin
          if (RejectZeroLen && (len_q == 32'h0)) begin
            state_q       <= StErr;
            err_o         <= 1'b1;
            err_code_o    <= 2'd3;
            mac_pending_q <= 1'b1;
          end else begin
            state_q <= mac_pending_q ? StMacLo : StSrc;
          end
        end
        StDone: state_q <= StIdle;
        StErr:  state_q <= StIdle;
        default: begin
          if (!reg_valid_o) begin
            // Launch the access one cycle after entering the state.
            reg_valid_o <= 1'b1;
            reg_addr_o  <= acc_addr;
            reg_write_o <= acc_write;
            reg_wdata_o <= acc_write ? acc_wdata : 32'h0;
            reg_wstrb_o <= acc_write ? 4'hF : 4'h0;
          end else if (reg_ready_i) begin
            reg_valid_o <= 1'b0;
            reg_addr_o  <= 32'h0;
            reg_write_o <= 1'b0;
            reg_wdata_o <= 32'h0;
            reg_wstrb_o <= 4'h0;
            if (reg_error_i) begin
              state_q       <= StErr;
              err_o         <= 1'b1;
              err_code_o    <= 2'd1;
              mac_pending_q <= 1'b1;
              poll_cnt_q    <= '0;
            end else if ((state_q == StPoll) && !reg_rdata_i[0]) begin
              if (poll_cnt_q == CntW'(PollMax - 1)) begin
                state_q       <= StErr;
                err_o         <= 1'b1;
                err_code_o    <= 2'd2;
                mac_pending_q <= 1'b1;
                poll_cnt_q    <= '0;
              end else begin
                poll_cnt_q <= poll_cnt_q + 1'b1;
              end
            end else begin
              if (state_q == StPoll)  poll_cnt_q    <= '0;
              if (state_q == StMacHi) mac_pending_q <= 1'b0;
              if (acc_next == StDone) done_o        <= 1'b1;
              state_q <= acc_next;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_idma_reg_sequencer.sv
// tb_eth_idma_reg_sequencer: scoreboard bench with a behavioural slave model.
module tb_eth_idma_reg_sequencer;

  localparam int PollMax = 16;

  logic        s_clk = 1'b0;
  logic        s_rst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_dir_i;
  logic [31:0] cmd_src_addr_i;
  logic [31:0] cmd_dst_addr_i;
  logic [31:0] cmd_len_i;
  logic        cmd_mac_upd_i;
  logic [47:0] mac_addr_i;
  logic [15:0] mac_cfg_i;
  logic [31:0] reg_addr_o;
  logic        reg_write_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic        reg_valid_o;
  logic [31:0] reg_rdata_i = 32'h0;
  logic        reg_error_i = 1'b0;
  logic        reg_ready_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  eth_idma_reg_sequencer #(.PollMax(PollMax)) dut (
    .s_clk          (s_clk),
    .s_rst_n        (s_rst_n),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_dir_i      (cmd_dir_i),
    .cmd_src_addr_i (cmd_src_addr_i),
    .cmd_dst_addr_i (cmd_dst_addr_i),
    .cmd_len_i      (cmd_len_i),
    .cmd_mac_upd_i  (cmd_mac_upd_i),
    .mac_addr_i     (mac_addr_i),
    .mac_cfg_i      (mac_cfg_i),
    .reg_addr_o     (reg_addr_o),
    .reg_write_o    (reg_write_o),
    .reg_wdata_o    (reg_wdata_o),
    .reg_wstrb_o    (reg_wstrb_o),
    .reg_valid_o    (reg_valid_o),
    .reg_rdata_i    (reg_rdata_i),
    .reg_error_i    (reg_error_i),
    .reg_ready_i    (reg_ready_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .err_code_o     (err_code_o)
  );

  always #5 s_clk = ~s_clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    int kind;  // 0 = done, 1 = error
    int code;
    int lat;   // -1 when not checked
  } outc_t;

  acc_t  exp_q[$];
  outc_t out_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int cmd_seq = 0;
  int cfg_zeros = 0;
  int cfg_err_at = -1;
  bit cfg_zero_wait = 1'b1;
  bit m_pending = 1'b1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got no/extra event, expected otherwise", name);
  endfunction

  function automatic acc_t mk(input logic [31:0] addr, input logic wr, input logic [31:0] data);
    acc_t a;
    a.addr = addr;
    a.wr   = wr;
    a.data = data;
    return a;
  endfunction

  always @(posedge s_clk) cyc++;

  // Slave model: checks each new access against the scoreboard, then answers.
  int          sl_seq = 0;
  int          sl_idx = 0;
  int          sl_polls = 0;
  int          sl_wait = 0;
  bit          sl_in_acc = 1'b0;
  bit          sl_prev_valid = 1'b0;
  logic [31:0] sl_addr;
  logic [31:0] sl_data;
  logic [31:0] sl_rnd;
  acc_t        sl_e;
  always @(negedge s_clk) begin
    reg_ready_i = 1'b0;
    reg_error_i = 1'b0;
    reg_rdata_i = $urandom();
    if (sl_seq != cmd_seq) begin
      sl_seq   = cmd_seq;
      sl_idx   = 0;
      sl_polls = 0;
    end
    if (!reg_valid_o) begin
      sl_in_acc = 1'b0;
    end else begin
      if (!sl_in_acc) begin
        sl_in_acc = 1'b1;
        chk("idle_gap", {63'h0, sl_prev_valid}, 64'h0);
        if (exp_q.size() == 0) begin
          fail("unexpected_access");
        end else begin
          sl_e = exp_q.pop_front();
          chk("acc_addr", reg_addr_o, sl_e.addr);
          chk("acc_write", reg_write_o, sl_e.wr);
          chk("acc_wstrb", reg_wstrb_o, sl_e.wr ? 4'hF : 4'h0);
          if (sl_e.wr) chk("acc_wdata", reg_wdata_o, sl_e.data);
        end
        sl_addr = reg_addr_o;
        sl_data = reg_wdata_o;
        sl_wait = cfg_zero_wait ? 0 : int'($urandom_range(0, 3));
      end else begin
        chk("stable_addr", reg_addr_o, sl_addr);
        chk("stable_wdata", reg_wdata_o, sl_data);
      end
      if (sl_wait == 0) begin
        reg_ready_i = 1'b1;
        if (!reg_write_o) begin
          sl_rnd      = $urandom();
          reg_rdata_i = {sl_rnd[31:1], (sl_polls < cfg_zeros) ? 1'b0 : 1'b1};
          sl_polls++;
        end
        reg_error_i = (sl_idx == cfg_err_at);
        sl_idx++;
      end else begin
        sl_wait--;
      end
    end
    sl_prev_valid = reg_valid_o;
  end

  // Outcome monitor: done/err pulses against expected outcomes.
  outc_t mon_o;
  bit    ready_chk = 1'b0;
  always @(negedge s_clk) begin
    if (ready_chk) begin
      chk("ready_after_pulse", cmd_ready_o, 1);
      chk("idle_after_pulse", busy_o, 0);
      ready_chk = 1'b0;
    end
    if (done_o || err_o) begin
      if (out_q.size() == 0) begin
        fail("unexpected_pulse");
      end else begin
        mon_o = out_q.pop_front();
        chk("pulse_kind", {done_o, err_o}, (mon_o.kind == 0) ? 2'b10 : 2'b01);
        chk("err_code", err_code_o, (mon_o.kind == 0) ? 0 : mon_o.code);
        if (mon_o.lat >= 0) chk("done_latency", cyc - accept_cyc, mon_o.lat);
      end
      ready_chk = 1'b1;
    end
  end

  // Reference model: expected access list and outcome from the command rules.
  task automatic issue(input bit dir, input logic [31:0] src, input logic [31:0] dst,
                       input logic [31:0] len, input bit upd, input int zeros,
                       input int err_idx, input bit zw);
    acc_t  lst[$];
    outc_t o;
    bit    mac_w;
    bit    timeout;
    int    nreads;
    int    n;
    logic [47:0] mac;
    mac   = mac_addr_i;
    mac_w = m_pending || upd;
    o.lat = -1;
    if (len == 32'h0) begin
      o.kind = 1;
      o.code = 3;
      m_pending = 1'b1;
    end else begin
      if (mac_w) begin
        lst.push_back(mk(32'h00, 1'b1, mac[31:0]));
        lst.push_back(mk(32'h04, 1'b1, {mac_cfg_i, mac[47:32]}));
      end
      lst.push_back(mk(32'h10, 1'b1, src));
      lst.push_back(mk(32'h14, 1'b1, dst));
      lst.push_back(mk(32'h18, 1'b1, len));
      lst.push_back(mk(32'h1C, 1'b1, dir ? 32'd5 : 32'd0));
      lst.push_back(mk(32'h20, 1'b1, dir ? 32'd0 : 32'd5));
      timeout = (zeros >= PollMax);
      nreads  = timeout ? PollMax : zeros + 1;
      for (int i = 0; i < nreads; i++) lst.push_back(mk(32'h3C, 1'b0, 32'h0));
      if (!timeout) begin
        lst.push_back(mk(32'h38, 1'b1, 32'h1));
        lst.push_back(mk(32'h38, 1'b1, 32'h0));
        lst.push_back(mk(32'h40, 1'b1, 32'h1));
      end
      if (err_idx >= 0 && err_idx < lst.size()) begin
        while (lst.size() > err_idx + 1) void'(lst.pop_back());
        o.kind = 1;
        o.code = 1;
        m_pending = 1'b1;
      end else if (timeout) begin
        o.kind = 1;
        o.code = 2;
        m_pending = 1'b1;
      end else begin
        o.kind = 0;
        o.code = 0;
        if (zw) o.lat = 2 * lst.size() + 2;
        if (mac_w) m_pending = 1'b0;
      end
    end
    n = 0;
    @(negedge s_clk);
    while (!cmd_ready_o && n < 1000) begin
      @(negedge s_clk);
      n++;
    end
    if (!cmd_ready_o) fail("cmd_ready_wait");
    cfg_zeros     = zeros;
    cfg_err_at    = err_idx;
    cfg_zero_wait = zw;
    cmd_seq++;
    foreach (lst[i]) exp_q.push_back(lst[i]);
    out_q.push_back(o);
    cmd_dir_i      = dir;
    cmd_src_addr_i = src;
    cmd_dst_addr_i = dst;
    cmd_len_i      = len;
    cmd_mac_upd_i  = upd;
    cmd_valid_i    = 1'b1;
    accept_cyc     = cyc;
    @(posedge s_clk);
    // Keep offering junk while busy; it must not be taken.
    #1;
    cmd_dir_i      = ~dir;
    cmd_src_addr_i = ~src;
    cmd_dst_addr_i = ~dst;
    cmd_len_i      = 32'h0;
    @(posedge s_clk);
    @(posedge s_clk);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic finish_cmd();
    int n = 0;
    while ((exp_q.size() != 0 || out_q.size() != 0) && n < 3000) begin
      @(negedge s_clk);
      n++;
    end
    if (n >= 3000) begin
      fail("cmd_timeout");
      exp_q.delete();
      out_q.delete();
    end
    repeat (3) @(negedge s_clk);
  endtask

  task automatic run(input bit dir, input logic [31:0] src, input logic [31:0] dst,
                     input logic [31:0] len, input bit upd, input int zeros,
                     input int err_idx, input bit zw);
    issue(dir, src, dst, len, upd, zeros, err_idx, zw);
    finish_cmd();
  endtask

  task automatic reset_mid_poll();
    int n = 0;
    issue(1'b0, 32'hA0, 32'hB0, 32'h10, 1'b0, 100, -1, 1'b0);
    while (!(reg_valid_o && reg_addr_o == 32'h3C) && n < 2000) begin
      @(negedge s_clk);
      n++;
    end
    if (n >= 2000) fail("poll_reached");
    #2;
    cmd_valid_i = 1'b1;
    s_rst_n     = 1'b1;
    #1;
    chk("rst_valid", reg_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", cmd_ready_o, 1);
    repeat (2) @(negedge s_clk);
    chk("rst_hold_busy", busy_o, 0);
    chk("rst_hold_valid", reg_valid_o, 0);
    cmd_valid_i = 1'b0;
    exp_q.delete();
    out_q.delete();
    m_pending = 1'b1;
    @(negedge s_clk);
    s_rst_n = 1'b0;
    @(negedge s_clk);
  endtask

  initial begin
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [31:0] r_len;
    int          z;
    int          e;
    s_rst_n        = 1'b1;
    cmd_valid_i    = 1'b0;
    cmd_dir_i      = 1'b0;
    cmd_src_addr_i = 32'h0;
    cmd_dst_addr_i = 32'h0;
    cmd_len_i      = 32'h0;
    cmd_mac_upd_i  = 1'b0;
    mac_addr_i     = 48'h0;
    mac_cfg_i      = 16'h0;
    repeat (3) @(negedge s_clk);
    chk("reset_cmd_ready", cmd_ready_o, 1);
    chk("reset_busy", busy_o, 0);
    chk("reset_reg_valid", reg_valid_o, 0);
    chk("reset_reg_addr", reg_addr_o, 0);
    chk("reset_reg_write", reg_write_o, 0);
    chk("reset_reg_wdata", reg_wdata_o, 0);
    chk("reset_reg_wstrb", reg_wstrb_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_err", err_o, 0);
    chk("reset_err_code", err_code_o, 0);
    s_rst_n = 1'b0;
    @(negedge s_clk);

    mac_addr_i = 48'h2070_9800_1032;
    mac_cfg_i  = 16'h0;
    run(1'b0, 32'h0, 32'h0, 32'h40, 1'b1, 0, -1, 1'b1);          // TX with MAC
    run(1'b1, 32'h1000, 32'h2000, 32'h80, 1'b0, 0, -1, 1'b1);    // RX, 20-cycle latency
    run(1'b0, 32'h11, 32'h22, 32'h33, 1'b0, 3, -1, 1'b1);        // 3 zero polls
    run(1'b1, 32'h44, 32'h55, 32'h66, 1'b0, PollMax - 1, -1, 1'b0);
    run(1'b0, 32'h77, 32'h88, 32'h99, 1'b0, PollMax, -1, 1'b0);  // poll timeout
    run(1'b0, 32'hAA, 32'hBB, 32'hCC, 1'b0, 0, -1, 1'b1);        // MAC rewritten
    run(1'b0, 32'h1, 32'h2, 32'h3, 1'b0, 0, (m_pending ? 2 : 0) + 2, 1'b1); // error on 0x18
    run(1'b1, 32'h5, 32'h6, 32'h0, 1'b0, 0, -1, 1'b1);           // zero length
    run(1'b0, 32'h7, 32'h8, 32'h9, 1'b0, 0, -1, 1'b0);           // MAC after error
    reset_mid_poll();
    run(1'b1, 32'hC0, 32'hD0, 32'hE0, 1'b0, 1, -1, 1'b1);        // full replay after reset

    for (int i = 0; i < 25; i++) begin
      r_src      = $urandom();
      r_dst      = $urandom();
      r_len      = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom();
      z          = ($urandom_range(0, 4) == 0) ? PollMax + int'($urandom_range(0, 2))
                                               : int'($urandom_range(0, 3));
      e          = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
      mac_addr_i = {16'($urandom()), 32'($urandom())};
      mac_cfg_i  = 16'($urandom());
      run(1'($urandom()), r_src, r_dst, r_len, 1'($urandom()), z, e, 1'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
